router_out_arb: RTL and testbench

ROUTER_OUT_ARB -- requirements
Module: router_out_arb

---
 rtl/router_pkg.sv | 21 ++
 rtl/rr_arb3.sv | 32 +++
 rtl/router_out_arb.sv | 106 ++++++++++
 tb/tb_router_out_arb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants for the router output arbiter: flit width, header codes,
// input port indices and the arbiter FSM encoding.
package router_pkg;

    localparam int unsigned WD_DEFAULT = 40;

    localparam logic [3:0] DEST_X     = 4'b0100;
    localparam logic [3:0] DEST_Y     = 4'b1000;
    localparam logic [3:0] DEST_LOCAL = 4'b0010;

    localparam logic [1:0] PORT_X     = 2'd0;
    localparam logic [1:0] PORT_Y     = 2'd1;
    localparam logic [1:0] PORT_LOCAL = 2'd2;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StBusy    = 2'd1,
        StBlocked = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin winner select: search starts at the port after last_ptr
// in the order x -> y -> local -> x. Purely combinational, one-hot grant.
module rr_arb3
    import router_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last_ptr,
    output logic [2:0] grant
);

    always_comb begin
        grant = 3'b000;
        case (last_ptr)
            PORT_X: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            PORT_Y: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/router_out_arb.sv
// Output-port arbiter: pops matching head flits from the x/y/local input FIFOs
// round-robin and forwards one registered flit per cycle to the next FIFO.
module router_out_arb
    import router_pkg::*;
#(
    parameter int unsigned WD        = WD_DEFAULT,
    parameter logic [3:0]  DEST_CODE = DEST_X
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          empty_x,
    input  logic          empty_y,
    input  logic          empty_local,
    input  logic [WD-1:0] head_x,
    input  logic [WD-1:0] head_y,
    input  logic [WD-1:0] head_local,
    input  logic          next_full,
    output logic          rd_x_en,
    output logic          rd_y_en,
    output logic          rd_local_en,
    output logic [WD-1:0] data_out,
    output logic          wr_next_en,
    output logic          blocked,
    output logic [15:0]   flit_cnt
);

    logic [2:0]    req;
    logic [2:0]    arb_grant;
    logic [2:0]    grant;
    logic          grant_en;
    logic [1:0]    last_ptr_q, win_idx;
    logic [WD-1:0] win_head;
    logic [WD-1:0] data_q;
    logic          wr_q;
    logic [15:0]   cnt_q;
    arb_state_e    state_q, state_d;

    assign req[0] = !empty_x     && (head_x[WD-1:WD-4]     == DEST_CODE);
    assign req[1] = !empty_y     && (head_y[WD-1:WD-4]     == DEST_CODE);
    assign req[2] = !empty_local && (head_local[WD-1:WD-4] == DEST_CODE);

    rr_arb3 u_rr_arb3 (
        .req      (req),
        .last_ptr (last_ptr_q),
        .grant    (arb_grant)
    );

    // Reset gates the pop strobes so a FIFO is never popped while in reset.
    assign grant_en = rst_n && !next_full && (|req);
    assign grant    = grant_en ? arb_grant : 3'b000;

    assign rd_x_en     = grant[0];
    assign rd_y_en     = grant[1];
    assign rd_local_en = grant[2];

    always_comb begin
        win_idx  = last_ptr_q;
        win_head = head_local;
        case (grant)
            3'b001: begin
                win_idx  = PORT_X;
                win_head = head_x;
            end
            3'b010: begin
                win_idx  = PORT_Y;
                win_head = head_y;
            end
            3'b100: begin
                win_idx  = PORT_LOCAL;
                win_head = head_local;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = StIdle;
        if (|req) begin
            state_d = next_full ? StBlocked : StBusy;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q     <= '0;
            wr_q       <= 1'b0;
            cnt_q      <= 16'h0000;
            last_ptr_q <= PORT_LOCAL;
            state_q    <= StIdle;
        end else begin
            state_q <= state_d;
            wr_q    <= grant_en;
            if (grant_en) begin
                data_q     <= win_head;
                last_ptr_q <= win_idx;
                cnt_q      <= cnt_q + 16'h0001;
            end
        end
    end

    assign data_out   = data_q;
    assign wr_next_en = wr_q;
    assign flit_cnt   = cnt_q;
    assign blocked    = (state_q == StBlocked);

endmodule

// File: tb/tb_router_out_arb.sv
// Scenario bench for router_out_arb: expected flits are queued when a grant is
// predicted and checked when the DUT writes them downstream.
module tb_router_out_arb;

    localparam int unsigned WD   = 40;
    localparam logic [3:0]  DEST = 4'b0100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          empty_x, empty_y, empty_local;
    logic [WD-1:0] head_x, head_y, head_local;
    logic          next_full;
    logic          rd_x_en, rd_y_en, rd_local_en;
    logic [WD-1:0] data_out;
    logic          wr_next_en;
    logic          blocked;
    logic [15:0]   flit_cnt;

    int            vectors    = 0;
    int            miscompares = 0;

    logic [WD-1:0] sb_q[$];
    int            mlast;
    logic [15:0]   exp_cnt;
    logic          exp_blocked;

    always #5 clk = ~clk;

    router_out_arb #(
        .WD        (WD),
        .DEST_CODE (DEST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .empty_x     (empty_x),
        .empty_y     (empty_y),
        .empty_local (empty_local),
        .head_x      (head_x),
        .head_y      (head_y),
        .head_local  (head_local),
        .next_full   (next_full),
        .rd_x_en     (rd_x_en),
        .rd_y_en     (rd_y_en),
        .rd_local_en (rd_local_en),
        .data_out    (data_out),
        .wr_next_en  (wr_next_en),
        .blocked     (blocked),
        .flit_cnt    (flit_cnt)
    );

    // Output monitor: every downstream write must match the oldest predicted flit.
    always @(posedge clk) begin
        #1;
        if (wr_next_en === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_write: data_out=%h, required no write", data_out);
            end else begin
                logic [WD-1:0] exp_d;
                exp_d = sb_q.pop_front();
                if (data_out !== exp_d) begin
                    miscompares++;
                    $display("FAIL sb_data: data_out=%h, required %h", data_out, exp_d);
                end
            end
        end
    end

    function automatic logic mreq(int i);
        case (i)
            0:       return !empty_x     && (head_x[WD-1:WD-4]     == DEST);
            1:       return !empty_y     && (head_y[WD-1:WD-4]     == DEST);
            default: return !empty_local && (head_local[WD-1:WD-4] == DEST);
        endcase
    endfunction

    function automatic int model_grant();
        if (rst_n !== 1'b1 || next_full) return -1;
        for (int k = 1; k <= 3; k++) begin
            if (mreq((mlast + k) % 3)) return (mlast + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [2:0] onehot(int g);
        logic [2:0] v;
        v = 3'b000;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Advances the model across the posedge that ends the current cycle.
    task automatic tick(input int g);
        logic any_req;
        any_req = mreq(0) || mreq(1) || mreq(2);
        if (g >= 0) begin
            sb_q.push_back(g == 0 ? head_x : (g == 1 ? head_y : head_local));
            mlast   = g;
            exp_cnt = exp_cnt + 16'h0001;
        end
        if (rst_n !== 1'b1) begin
            mlast       = 2;
            exp_cnt     = 16'h0000;
            exp_blocked = 1'b0;
        end else begin
            exp_blocked = any_req && next_full;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic set_inputs(input logic ex, input logic ey, input logic el);
        empty_x     = ex;
        empty_y     = ey;
        empty_local = el;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tick(-1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        next_full  = 1'b0;
        head_x     = 40'h40_0000_0001;
        head_y     = 40'h40_0000_0002;
        head_local = 40'h40_0000_0003;
        set_inputs(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({rd_local_en, rd_y_en, rd_x_en} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_rd: rd=%b, required 000", {rd_local_en, rd_y_en, rd_x_en});
            end
            tick(-1);
            vectors++;
            if (data_out !== '0 || flit_cnt !== 16'h0 || blocked !== 1'b0 || wr_next_en !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_regs: data=%h cnt=%h blk=%b wr=%b, required 0 0 0 0",
                         data_out, flit_cnt, blocked, wr_next_en);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rr_all();
        int g;
        set_inputs(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            g = model_grant();
            vectors++;
            if ({rd_local_en, rd_y_en, rd_x_en} !== onehot(c % 3) || g != c % 3) begin
                miscompares++;
                $display("FAIL rr_order: cycle %0d rd=%b, required %b", c,
                         {rd_local_en, rd_y_en, rd_x_en}, onehot(c % 3));
            end
            tick(g);
            vectors++;
            if (wr_next_en !== 1'b1 || flit_cnt !== exp_cnt) begin
                miscompares++;
                $display("FAIL rr_wr: cycle %0d wr=%b cnt=%0d, required 1 %0d", c,
                         wr_next_en, flit_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_single_x();
        apply_reset();
        set_inputs(1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if ({rd_local_en, rd_y_en, rd_x_en} !== 3'b001) begin
                miscompares++;
                $display("FAIL single_x_rd: cycle %0d rd=%b, required 001", c,
                         {rd_local_en, rd_y_en, rd_x_en});
            end
            head_x = 40'h40_0000_0100 + 40'(c);
            tick(model_grant());
            vectors++;
            if (wr_next_en !== 1'b1) begin
                miscompares++;
                $display("FAIL single_x_wr: cycle %0d wr=%b, required 1", c, wr_next_en);
            end
        end
        set_inputs(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        tick(model_grant());
        vectors++;
        if (flit_cnt !== 16'd5 || wr_next_en !== 1'b0) begin
            miscompares++;
            $display("FAIL single_x_cnt: cnt=%0d wr=%b, required 5 0", flit_cnt, wr_next_en);
        end
    endtask

    task automatic test_backpressure();
        int g;
        logic [2:0] exp_seq[6];
        exp_seq = '{3'b001, 3'b010, 3'b000, 3'b100, 3'b001, 3'b010};
        apply_reset();
        head_x = 40'h40_0000_0001;
        set_inputs(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            next_full = (c == 2);
            @(negedge clk);
            g = model_grant();
            vectors++;
            if ({rd_local_en, rd_y_en, rd_x_en} !== exp_seq[c] || onehot(g) != exp_seq[c]) begin
                miscompares++;
                $display("FAIL bp_rd: cycle %0d rd=%b, required %b", c,
                         {rd_local_en, rd_y_en, rd_x_en}, exp_seq[c]);
            end
            tick(g);
            vectors++;
            if (blocked !== (c == 2) || wr_next_en !== (c != 2) || blocked !== exp_blocked) begin
                miscompares++;
                $display("FAIL bp_state: cycle %0d blk=%b wr=%b, required %b %b", c,
                         blocked, wr_next_en, c == 2, c != 2);
            end
        end
        next_full = 1'b0;
    endtask

    task automatic test_mismatch();
        logic [15:0] cnt0;
        set_inputs(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        tick(model_grant());
        cnt0   = flit_cnt;
        head_y = 40'h20_0000_00AA;
        for (int c = 0; c < 6; c++) begin
            // Second half adds a matching x flit beside the foreign y flit.
            set_inputs(c < 3, 1'b0, 1'b1);
            next_full = (c == 1);
            @(negedge clk);
            vectors++;
            if (rd_y_en !== 1'b0 || rd_local_en !== 1'b0 || rd_x_en !== (c >= 3)) begin
                miscompares++;
                $display("FAIL mismatch_rd: cycle %0d rd=%b, required %b", c,
                         {rd_local_en, rd_y_en, rd_x_en}, onehot(c >= 3 ? 0 : -1));
            end
            tick(model_grant());
            vectors++;
            if (blocked !== 1'b0 || blocked !== exp_blocked ||
                (c < 3 && (wr_next_en !== 1'b0 || flit_cnt !== cnt0))) begin
                miscompares++;
                $display("FAIL mismatch_idle: cycle %0d blk=%b wr=%b cnt=%0d, required 0 0 %0d",
                         c, blocked, wr_next_en, flit_cnt, cnt0);
            end
        end
        next_full = 1'b0;
        set_inputs(1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_wrap();
        apply_reset();
        set_inputs(1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 65535; c++) begin
            head_x = {DEST, 36'(c)};
            @(negedge clk);
            if (rd_x_en !== 1'b1) begin
                vectors++;
                miscompares++;
                $display("FAIL wrap_rd: cycle %0d rd_x_en=%b, required 1", c, rd_x_en);
            end
            tick(model_grant());
        end
        vectors++;
        if (flit_cnt !== 16'hFFFF || exp_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_pre: cnt=%h, required ffff", flit_cnt);
        end
        head_x = 40'h4F_FFFF_FFFF;
        @(negedge clk);
        tick(model_grant());
        vectors++;
        if (flit_cnt !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_cnt: cnt=%h, required 0000", flit_cnt);
        end
        set_inputs(1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_drain();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tick(model_grant());
        end
        vectors++;
        if (sb_q.size() != 0 || wr_next_en !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: %0d flits never written, wr=%b, required 0 0",
                     sb_q.size(), wr_next_en);
        end
    endtask

    initial begin
        mlast       = 2;
        exp_cnt     = 16'h0000;
        exp_blocked = 1'b0;
        test_reset();
        test_rr_all();
        test_single_x();
        test_backpressure();
        test_mismatch();
        test_wrap();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
